pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Centralised pipeline control for the five-stage Y86-64 core. It detects load/use, ret and branch-mispredict hazards and drives stall/bubble lines into f_reg..w_reg. It replaces the ad-hoc stat/halt logic at the processor top with a registered run/drain/halt/fault state machine, a retirement watchdog and saturating performance counters. It sits beside the pipeline registers; all hazard outputs are combinational from stage fields, and all status and counters are registered.

Parameters:
CNT_W, 32, width of each performance counter
WDOG_W, 16, width of the watchdog counter
WDOG_LIMIT, 0, cycles in RUN without a retirement before FAULT; 0 disables the watchdog
RNONE, 4'hF, "no register" encoding for srcA/srcB/dstM

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
d_icode  in  4  decode-stage icode
d_srcA  in  4  decode source A register id
d_srcB  in  4  decode source B register id
e_icode  in  4  execute-stage icode
e_dstM  in  4  execute-stage memory destination register
e_cnd  in  1  execute condition result
m_icode  in  4  memory-stage icode
m_stat  in  3  memory-stage status after dmem check
w_stat  in  3  writeback-stage status
w_icode  in  4  writeback-stage icode
drain_req  in  1  level; request pipeline drain
resume_req  in  1  pulse; leave DRAINED
cnt_clr  in  1  synchronous clear of all performance counters
f_stall, d_stall, w_stall  out  1 each  hold the corresponding pipeline register
d_bubble, e_bubble, m_bubble  out  1 each  load NOP/AOK into the corresponding register
setcc_en  out  1  condition-code write enable for execute
proc_stat  out  3  one-hot {HLT,INS,AOK}
state  out  2  FSM state
timeout  out  1  sticky; set when FAULT was caused by the watchdog
cycle_cnt, retire_cnt, bubble_cnt, stall_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (asynchronous): state=RUN, proc_stat=AOK (3'b001), timeout=0, watchdog=0, all counters=0.
- Hazard terms (combinational):
  - lu = e_icode in {MRMOVQ, POPQ} and e_dstM != RNONE and e_dstM in {d_srcA, d_srcB}
  - rt = RET in {d_icode, e_icode, m_icode}
  - mp = e_icode==JXX and !e_cnd
  - exc_m = m_stat != AOK
  - exc_w = w_stat != AOK
- Outputs in RUN:
  - f_stall = lu | rt
  - d_stall = lu
  - d_bubble = mp | (rt & !lu)
  - e_bubble = mp | lu
  - m_bubble = exc_m | exc_w
  - w_stall = exc_w
  - setcc_en = e_icode==OPQ & !exc_m & !exc_w
  - A register never sees stall and bubble together; stall wins.
- FSM:
  - RUN: exc_w with w_stat==HLT -> HALTED. exc_w with INS -> FAULT. Watchdog reaches WDOG_LIMIT -> FAULT with timeout=1. Otherwise drain_req -> DRAINING. Exception takes priority over drain.
  - DRAINING: f_stall=1 and d_bubble=1 every cycle; the E/M/W hazard rules above still apply. When e_icode, m_icode and w_icode are all NOP and d_icode is NOP -> DRAINED. An exception arriving at W -> HALTED/FAULT as in RUN.
  - DRAINED: f_stall=d_stall=w_stall=1, all bubbles 0. resume_req & !drain_req -> RUN.
  - HALTED / FAULT: terminal until rst. f_stall=d_stall=w_stall=1, all bubbles 0, setcc_en=0.
- proc_stat updates one cycle after W presents a non-AOK stat, together with the state change, and then holds.
- Watchdog:
  - Increments in RUN when w_icode==NOP. Clears on any non-NOP retirement or on leaving RUN.
  - Saturates at WDOG_LIMIT. Inactive when WDOG_LIMIT==0.
- Counters: all saturate at all-ones, never wrap; cnt_clr has priority over increment.
  - cycle_cnt: +1 every cycle not in HALTED/FAULT.
  - retire_cnt: +1 when w_icode != NOP, w_stat==AOK, and w_stall=0.
  - bubble_cnt: +1 when e_bubble.
  - stall_cnt: +1 when f_stall in RUN or DRAINING.
- rst mid-drain or mid-hazard returns to RUN immediately and clears timeout.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT=0 … POPQ=4'hB)
  - stat encodings AOK=3'b001, INS=3'b010, HLT=3'b100
  - RNONE
  - state encodings RUN=0, DRAINING=1, DRAINED=2 (HALTED=3 plus a fault flag)
  - Alternatively, state is 3 bits with FAULT=4; implementer chooses, stated in the package.
- One sub-module, pipe_sat_cnt (parametrised width, inc, clr, async rst), instanced four times.

Test Plan:
- Load/use: e_icode=MRMOVQ, e_dstM=2, d_srcA=2 -> f_stall=1, d_stall=1, e_bubble=1, d_bubble=0. Same with d_srcA=3, d_srcB=RNONE -> all 0.
- Ret plus load/use: d_icode=RET with the load/use above -> d_stall=1, d_bubble=0. Ret alone in E -> f_stall=1, d_bubble=1.
- Mispredict: e_icode=JXX, e_cnd=0 -> d_bubble=e_bubble=1. With e_cnd=1 -> 0. bubble_cnt increments by exactly one per asserted cycle.
- Halt: w_stat=HLT for one cycle -> next edge state=HALTED, proc_stat=3'b100, all stalls 1. cycle_cnt frozen thereafter. INS instead gives FAULT, proc_stat=3'b010.
- Drain: drain_req=1 with a non-NOP instruction in E -> DRAINING with f_stall=1. After three NOP-only cycles -> DRAINED. resume_req pulse -> RUN.
- Watchdog: WDOG_LIMIT=5, w_icode=NOP for 5 cycles in RUN -> FAULT, timeout=1. A retirement at cycle 4 resets the watchdog, and no FAULT occurs. Async rst asserted mid-count -> RUN, timeout=0, counters 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for pipeline control: icodes, stat codes, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  // One-hot status codes {HLT,INS,AOK}
  localparam logic [2:0] AOK = 3'b001;
  localparam logic [2:0] INS = 3'b010;
  localparam logic [2:0] HLT = 3'b100;

  // "No register" id
  localparam logic [3:0] RNONE = 4'hF;

  // Two-bit state. HALTED and FAULT share encoding 3 (S_STOP): both are
  // terminal with identical control outputs, and proc_stat/timeout tell
  // them apart (HLT -> halted; INS or timeout -> fault).
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_DRAINING = 2'd1,
    S_DRAINED  = 2'd2,
    S_STOP     = 2'd3
  } pipe_state_t;

  // Processor status latched when a non-AOK stat reaches writeback
  function automatic logic [2:0] stop_stat(input logic [2:0] w_stat);
    return (w_stat == HLT) ? HLT : INS;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count visible one cycle after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
module pipe_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear first, then increment unless already saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble lines, run/drain/halt/fault FSM, watchdog, perf counters.
// Latency: stall/bubble/setcc combinational from stage fields; state, status and counters registered (1 cycle).
// Backpressure: stalls hold f/d/w registers; drain empties the pipe before DRAINED; HALTED/FAULT freeze until rst.
module pipe_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDOG_W     = 16,
  parameter int unsigned WDOG_LIMIT = 0,
  parameter logic [3:0]  RNONE      = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       m_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       w_stat,
  input  logic [3:0]       w_icode,
  input  logic             drain_req,
  input  logic             resume_req,
  input  logic             cnt_clr,
  output logic             f_stall,
  output logic             d_stall,
  output logic             w_stall,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             m_bubble,
  output logic             setcc_en,
  output logic [2:0]       proc_stat,
  output logic [1:0]       state,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  import y86_pkg::*;

  pipe_state_t       state_q;
  logic [WDOG_W-1:0] wdog;

  // Hazard terms from the stage fields
  logic lu, rt, mp, exc_m, exc_w, is_opq, pipe_empty, wdog_hit;

  assign lu = (e_icode == MRMOVQ || e_icode == POPQ) && (e_dstM != RNONE) &&
              (e_dstM == d_srcA || e_dstM == d_srcB);
  assign rt = (d_icode == RET) || (e_icode == RET) || (m_icode == RET);
  assign mp = (e_icode == JXX) && !e_cnd;
  assign exc_m  = (m_stat != AOK);
  assign exc_w  = (w_stat != AOK);
  assign is_opq = (e_icode == OPQ);
  assign pipe_empty = (d_icode == NOP) && (e_icode == NOP) &&
                      (m_icode == NOP) && (w_icode == NOP);

  // Fires on the cycle whose idle writeback would bring the count to the limit
  assign wdog_hit = (WDOG_LIMIT != 0) && (w_icode == NOP) &&
                    (wdog == WDOG_W'(WDOG_LIMIT - 1));

  // Stall/bubble/setcc decode; stall wins over bubble on the same register
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    w_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    setcc_en = 1'b0;
    case (state_q)
      S_RUN: begin
        f_stall  = lu | rt;
        d_stall  = lu;
        d_bubble = (mp | (rt & !lu)) & !lu;
        e_bubble = mp | lu;
        m_bubble = exc_m | exc_w;
        w_stall  = exc_w;
        setcc_en = is_opq & !exc_m & !exc_w;
      end
      S_DRAINING: begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
        e_bubble = mp | lu;
        m_bubble = exc_m | exc_w;
        w_stall  = exc_w;
        setcc_en = is_opq & !exc_m & !exc_w;
      end
      default: begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        w_stall = 1'b1;
      end
    endcase
  end

  // Run/drain/halt/fault state machine with status, timeout flag and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      proc_stat <= AOK;
      timeout   <= 1'b0;
      wdog      <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (exc_w) begin
            state_q   <= S_STOP;
            proc_stat <= stop_stat(w_stat);
            wdog      <= '0;
          end else if (wdog_hit) begin
            state_q <= S_STOP;
            timeout <= 1'b1;
            wdog    <= '0;
          end else if (drain_req) begin
            state_q <= S_DRAINING;
            wdog    <= '0;
          end else if (w_icode != NOP) begin
            wdog <= '0;
          end else if (WDOG_LIMIT != 0 && wdog != WDOG_W'(WDOG_LIMIT)) begin
            wdog <= wdog + 1'b1;
          end
        end
        S_DRAINING: begin
          if (exc_w) begin
            state_q   <= S_STOP;
            proc_stat <= stop_stat(w_stat);
          end else if (pipe_empty) begin
            state_q <= S_DRAINED;
          end
        end
        S_DRAINED: begin
          if (resume_req && !drain_req) state_q <= S_RUN;
        end
        default: state_q <= S_STOP;
      endcase
    end
  end

  assign state = state_q;

  logic cyc_inc, ret_inc, stl_inc;
  assign cyc_inc = (state_q != S_STOP);
  assign ret_inc = (w_icode != NOP) && (w_stat == AOK) && !w_stall;
  assign stl_inc = f_stall && (state_q == S_RUN || state_q == S_DRAINING);

  pipe_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(rst), .inc(cyc_inc),  .clr(cnt_clr), .cnt(cycle_cnt));
  pipe_sat_cnt #(.W(CNT_W)) u_retire_cnt (
    .clk(clk), .rst(rst), .inc(ret_inc),  .clr(cnt_clr), .cnt(retire_cnt));
  pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(e_bubble), .clr(cnt_clr), .cnt(bubble_cnt));
  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stl_inc),  .clr(cnt_clr), .cnt(stall_cnt));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/FSM scenarios plus randomized hazards against a cycle model.
// Latency: outputs sampled on the falling edge; inputs driven right after sampling.
// Backpressure: n/a.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam int CW    = 8;
  localparam int LIMIT = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] d_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode, w_icode;
  logic       e_cnd, drain_req, resume_req, cnt_clr;
  logic [2:0] m_stat, w_stat;
  logic f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, setcc_en, timeout;
  logic [2:0] proc_stat;
  logic [1:0] state;
  logic [CW-1:0] cycle_cnt, retire_cnt, bubble_cnt, stall_cnt;

  pipe_ctrl #(.CNT_W(CW), .WDOG_W(16), .WDOG_LIMIT(LIMIT), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst),
    .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
    .m_icode(m_icode), .m_stat(m_stat), .w_stat(w_stat), .w_icode(w_icode),
    .drain_req(drain_req), .resume_req(resume_req), .cnt_clr(cnt_clr),
    .f_stall(f_stall), .d_stall(d_stall), .w_stall(w_stall),
    .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble),
    .setcc_en(setcc_en), .proc_stat(proc_stat), .state(state), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  wire [6:0]      ctl     = {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, setcc_en};
  wire [4*CW-1:0] cnt_obs = {cycle_cnt, retire_cnt, bubble_cnt, stall_cnt};

  int total = 0;
  int bad   = 0;

  // Reference model: 0 run, 1 draining, 2 drained, 3 halted, 4 fault
  int       ms;
  logic [2:0] mpstat;
  bit       mto;
  int       mwd;
  int       mc[4];   // cycle, retire, bubble, stall

  function automatic logic [6:0] exp_ctl();
    bit lu, rt, mp, em, ew, sc;
    lu = (e_icode == MRMOVQ || e_icode == POPQ) && e_dstM != 4'hF &&
         (e_dstM == d_srcA || e_dstM == d_srcB);
    rt = (d_icode == RET) || (e_icode == RET) || (m_icode == RET);
    mp = (e_icode == JXX) && !e_cnd;
    em = (m_stat != AOK);
    ew = (w_stat != AOK);
    sc = (e_icode == OPQ) && !em && !ew;
    if (ms == 0)
      return {lu | rt, lu, ew, mp | (rt & !lu), mp | lu, em | ew, sc};
    else if (ms == 1)
      return {1'b1, 1'b0, ew, 1'b1, mp | lu, em | ew, sc};
    else
      return 7'b1110000;
  endfunction

  function automatic logic [1:0] exp_state();
    return (ms == 4) ? 2'd3 : 2'(ms);
  endfunction

  function automatic logic [4*CW-1:0] exp_cnt();
    return {CW'(mc[0]), CW'(mc[1]), CW'(mc[2]), CW'(mc[3])};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  // Model advances on the same edges as the DUT, from the inputs held across the edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms = 0; mpstat = AOK; mto = 0; mwd = 0;
      for (int i = 0; i < 4; i++) mc[i] = 0;
    end else begin
      logic [6:0] c;
      bit ew;
      c  = exp_ctl();
      ew = (w_stat != AOK);
      if (cnt_clr) begin
        for (int i = 0; i < 4; i++) mc[i] = 0;
      end else begin
        if (ms < 3) mc[0] = sat_inc(mc[0]);
        if (w_icode != NOP && w_stat == AOK && !c[4]) mc[1] = sat_inc(mc[1]);
        if (c[2]) mc[2] = sat_inc(mc[2]);
        if (c[6] && ms < 2) mc[3] = sat_inc(mc[3]);
      end
      case (ms)
        0: begin
          if (ew) begin
            ms = (w_stat == HLT) ? 3 : 4; mpstat = (w_stat == HLT) ? HLT : INS; mwd = 0;
          end else if (w_icode == NOP && mwd + 1 >= LIMIT) begin
            ms = 4; mto = 1; mwd = 0;
          end else begin
            mwd = (w_icode == NOP) ? mwd + 1 : 0;
            if (drain_req) begin ms = 1; mwd = 0; end
          end
        end
        1: begin
          if (ew) begin
            ms = (w_stat == HLT) ? 3 : 4; mpstat = (w_stat == HLT) ? HLT : INS;
          end else if (d_icode == NOP && e_icode == NOP && m_icode == NOP && w_icode == NOP) begin
            ms = 2;
          end
        end
        2: if (resume_req && !drain_req) ms = 0;
        default: ;
      endcase
    end
  end

  task automatic set_defaults();
    d_icode = NOP; d_srcA = 4'd0; d_srcB = 4'd1;
    e_icode = NOP; e_dstM = 4'hF; e_cnd = 1'b1;
    m_icode = NOP; m_stat = AOK;
    w_icode = IRMOVQ; w_stat = AOK;
    drain_req = 1'b0; resume_req = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    set_defaults();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_defaults();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (proc_stat !== AOK) begin bad++; $display("FAIL reset_pstat got=%b want=001", proc_stat); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    total++; if (cnt_obs !== '0) begin bad++; $display("FAIL reset_counters got=%h want=0", cnt_obs); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (cnt_obs !== exp_cnt()) begin bad++; $display("FAIL first_cycle_counters got=%h want=%h", cnt_obs, exp_cnt()); end
  endtask

  task automatic test_load_use();
    set_defaults();
    d_icode = OPQ; e_icode = MRMOVQ; e_dstM = 4'd2; d_srcA = 4'd2; d_srcB = 4'hF;
    @(negedge clk);
    total++; if ({f_stall, d_stall, e_bubble, d_bubble} !== 4'b1110) begin bad++;
      $display("FAIL lu_hit got=%b want=1110", {f_stall, d_stall, e_bubble, d_bubble}); end
    total++; if (ctl !== exp_ctl()) begin bad++; $display("FAIL lu_hit_ctl got=%b want=%b", ctl, exp_ctl()); end
    d_srcA = 4'd3;
    @(negedge clk);
    total++; if ({f_stall, d_stall, e_bubble, d_bubble} !== 4'b0000) begin bad++;
      $display("FAIL lu_miss got=%b want=0000", {f_stall, d_stall, e_bubble, d_bubble}); end
    e_icode = POPQ; d_srcB = 4'd2;
    @(negedge clk);
    total++; if ({f_stall, d_stall, e_bubble, d_bubble} !== 4'b1110) begin bad++;
      $display("FAIL lu_popq_srcb got=%b want=1110", {f_stall, d_stall, e_bubble, d_bubble}); end
    e_dstM = 4'hF; d_srcB = 4'hF;
    @(negedge clk);
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL lu_rnone got=%b want=0", d_stall); end
  endtask

  task automatic test_ret();
    set_defaults();
    d_icode = RET; e_icode = MRMOVQ; e_dstM = 4'd2; d_srcA = 4'd2;
    @(negedge clk);
    total++; if ({f_stall, d_stall, d_bubble} !== 3'b110) begin bad++;
      $display("FAIL ret_lu got=%b want=110", {f_stall, d_stall, d_bubble}); end
    d_icode = NOP; e_icode = RET; e_dstM = 4'hF;
    @(negedge clk);
    total++; if ({f_stall, d_stall, d_bubble} !== 3'b101) begin bad++;
      $display("FAIL ret_e got=%b want=101", {f_stall, d_stall, d_bubble}); end
  endtask

  task automatic test_mispredict();
    int b0;
    set_defaults();
    e_icode = JXX; e_cnd = 1'b0;
    @(negedge clk);
    total++; if ({d_bubble, e_bubble} !== 2'b11) begin bad++;
      $display("FAIL mp_taken got=%b want=11", {d_bubble, e_bubble}); end
    b0 = mc[2];
    repeat (3) @(negedge clk);
    e_cnd = 1'b1;
    @(negedge clk);
    total++; if ({d_bubble, e_bubble} !== 2'b00) begin bad++;
      $display("FAIL mp_not got=%b want=00", {d_bubble, e_bubble}); end
    total++; if (bubble_cnt !== CW'(b0 + 3)) begin bad++;
      $display("FAIL mp_bubble_cnt got=%0d want=%0d", bubble_cnt, b0 + 3); end
  endtask

  task automatic test_random();
    set_defaults();
    for (int k = 0; k < 200; k++) begin
      d_icode = 4'($urandom_range(11, 0));
      e_icode = 4'($urandom_range(11, 0));
      m_icode = 4'($urandom_range(11, 0));
      w_icode = 4'($urandom_range(11, 2));
      d_srcA  = 4'($urandom_range(15, 0));
      d_srcB  = 4'($urandom_range(15, 0));
      e_dstM  = ($urandom % 2 == 0) ? d_srcA : 4'($urandom_range(15, 0));
      e_cnd   = 1'($urandom % 2);
      case ($urandom % 6)
        0: m_stat = INS;
        1: m_stat = HLT;
        default: m_stat = AOK;
      endcase
      cnt_clr = ($urandom % 40 == 0);
      @(negedge clk);
      total++; if (ctl !== exp_ctl()) begin bad++; $display("FAIL rnd_ctl k=%0d got=%b want=%b", k, ctl, exp_ctl()); end
      total++; if (cnt_obs !== exp_cnt()) begin bad++; $display("FAIL rnd_cnt k=%0d got=%h want=%h", k, cnt_obs, exp_cnt()); end
      total++; if (state !== exp_state()) begin bad++; $display("FAIL rnd_state k=%0d got=%0d want=%0d", k, state, exp_state()); end
    end
  endtask

  task automatic test_saturate();
    set_defaults();
    e_icode = JXX; e_cnd = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    total++; if (cnt_obs !== '0) begin bad++; $display("FAIL clr_priority got=%h want=0", cnt_obs); end
    cnt_clr = 1'b0;
    repeat (300) @(negedge clk);
    total++; if ({cycle_cnt, retire_cnt, bubble_cnt} !== {3{8'hFF}}) begin bad++;
      $display("FAIL saturate got=%h want=ffffff", {cycle_cnt, retire_cnt, bubble_cnt}); end
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL sat_stall got=%0d want=0", stall_cnt); end
    total++; if (cnt_obs !== exp_cnt()) begin bad++; $display("FAIL sat_model got=%h want=%h", cnt_obs, exp_cnt()); end
  endtask

  task automatic test_drain();
    logic [3:0] pd, pe, pm, pw;
    bit reached;
    set_defaults();
    pd = OPQ; pe = OPQ; pm = OPQ; pw = OPQ;
    d_icode = pd; e_icode = pe; m_icode = pm; w_icode = pw;
    drain_req = 1'b1;
    reached = 0;
    for (int k = 0; k < 12 && !reached; k++) begin
      @(negedge clk);
      total++; if (ctl !== exp_ctl()) begin bad++; $display("FAIL drain_ctl k=%0d got=%b want=%b", k, ctl, exp_ctl()); end
      total++; if (state !== exp_state()) begin bad++; $display("FAIL drain_state k=%0d got=%0d want=%0d", k, state, exp_state()); end
      if (ms == 1) begin
        total++; if (f_stall !== 1'b1) begin bad++; $display("FAIL drain_fstall k=%0d got=%b want=1", k, f_stall); end
        pw = pm; pm = pe; pe = pd; pd = NOP;
        d_icode = pd; e_icode = pe; m_icode = pm; w_icode = pw;
      end
      if (ms == 2) reached = 1;
    end
    total++; if (!reached || state !== 2'd2) begin bad++; $display("FAIL drain_done got=%0d want=2", state); end
    resume_req = 1'b1;
    @(negedge clk);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL resume_blocked got=%0d want=2", state); end
    drain_req = 1'b0; w_icode = IRMOVQ;
    @(negedge clk);
    resume_req = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL resume got=%0d want=0", state); end
  endtask

  task automatic test_watchdog();
    int cf;
    set_defaults();
    w_icode = NOP;
    repeat (4) @(negedge clk);
    w_icode = IRMOVQ;
    @(negedge clk);
    w_icode = NOP;
    repeat (4) @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL wdog_retire_reset got=%0d want=0", state); end
    @(negedge clk);
    total++; if (state !== 2'd3 || timeout !== 1'b1) begin bad++;
      $display("FAIL wdog_fault got=%0d/%b want=3/1", state, timeout); end
    total++; if (ctl !== 7'b1110000) begin bad++; $display("FAIL wdog_ctl got=%b want=1110000", ctl); end
    cf = mc[0];
    repeat (3) @(negedge clk);
    total++; if (cycle_cnt !== CW'(cf)) begin bad++; $display("FAIL fault_frozen got=%0d want=%0d", cycle_cnt, cf); end
    // asynchronous reset well away from the rising edge
    #2 rst = 1'b1;
    #1;
    total++; if (state !== 2'd0 || timeout !== 1'b0 || cnt_obs !== '0) begin bad++;
      $display("FAIL async_rst got=%0d/%b/%h want=0/0/0", state, timeout, cnt_obs); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL wdog_rst_midcount got=%0d want=0", state); end
    w_icode = IRMOVQ;
    @(negedge clk);
  endtask

  task automatic test_halt();
    int cf;
    logic [2:0] codes [2];
    codes[0] = HLT; codes[1] = INS;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      @(negedge clk);
      w_stat = codes[t]; w_icode = (t == 0) ? HALT : OPQ; e_icode = OPQ;
      #2;
      total++; if (ctl !== exp_ctl()) begin bad++; $display("FAIL exc_w_ctl t=%0d got=%b want=%b", t, ctl, exp_ctl()); end
      @(negedge clk);
      w_stat = AOK; w_icode = IRMOVQ;
      total++; if (state !== 2'd3 || proc_stat !== codes[t]) begin bad++;
        $display("FAIL stop t=%0d got=%0d/%b want=3/%b", t, state, proc_stat, codes[t]); end
      total++; if (ctl !== 7'b1110000 || timeout !== 1'b0) begin bad++;
        $display("FAIL stop_ctl t=%0d got=%b/%b want=1110000/0", t, ctl, timeout); end
      cf = mc[0];
      repeat (4) @(negedge clk);
      total++; if (cycle_cnt !== CW'(cf) || proc_stat !== mpstat) begin bad++;
        $display("FAIL stop_hold t=%0d got=%0d/%b want=%0d/%b", t, cycle_cnt, proc_stat, cf, mpstat); end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_ret();
    test_mispredict();
    test_random();
    test_saturate();
    test_drain();
    test_watchdog();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
